// File: rtl/led_pattern_decoder_if.sv
// LED bus bundle between the chaser side (master) and the pattern decoder (slave).
// The observed LED value flows into the decoder; the decoder's status flows back out.
interface led_pattern_decoder_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       led;
  logic [1:0]       mode;
  logic [3:0]       step;
  logic             done;
  logic             abort;
  logic             err;
  logic             in_err;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output led,
    input  mode, step, done, abort, err, in_err, err_cnt
  );

  modport slave (
    input  led,
    output mode, step, done, abort, err, in_err, err_cnt
  );
endinterface

// File: rtl/led_pattern_decoder.sv
// Receive-side checker for the 8-LED chaser bus. Recognises the fill sequence
// (00, 80, C0, ..., FF, 00) and the walking-dot sequence (00, 80, 40, ..., 01, 00),
// reports mode/step, pulses on completion/abort, and flags and counts illegal patterns.
module led_pattern_decoder #(
  parameter int CNT_W = 8
) (
  input  logic                  ck,
  input  logic                  rs,
  led_pattern_decoder_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_DOT   = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state, state_nx;
  logic [3:0]       step_q, step_nx;
  logic [1:0]       mode_q, mode_nx;
  logic             done_q, done_nx;
  logic             abort_q, abort_nx;
  logic             err_q, err_nx;
  logic             in_err_q;
  logic [CNT_W-1:0] cnt_q;

  // Fill pattern with the top k LEDs lit (k = 0..8).
  function automatic logic [7:0] fill_pat(input logic [3:0] k);
    return ~(8'hFF >> k);
  endfunction

  // Walking-dot pattern with the single lit LED at position p (p = 1..8, 1 = bit 7).
  function automatic logic [7:0] dot_pat(input logic [3:0] p);
    return 8'h80 >> (p - 4'd1);
  endfunction

  // Next-state decode: one legal successor per state, 00 ends a sequence, anything else is an error.
  always_comb begin
    state_nx = state;
    step_nx  = step_q;
    done_nx  = 1'b0;
    abort_nx = 1'b0;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        step_nx = 4'd0;
        if (bus.led == 8'h80) begin
          state_nx = S_START;
          step_nx  = 4'd1;
        end else if (bus.led != 8'h00) begin
          state_nx = S_ERR;
          err_nx   = 1'b1;
        end
      end
      S_START: begin
        if (bus.led == 8'hC0) begin
          state_nx = S_FILL;
          step_nx  = 4'd2;
        end else if (bus.led == 8'h40) begin
          state_nx = S_DOT;
          step_nx  = 4'd2;
        end else if (bus.led == 8'h00) begin
          state_nx = S_IDLE;
          step_nx  = 4'd0;
          abort_nx = 1'b1;
        end else begin
          state_nx = S_ERR;
          step_nx  = 4'd0;
          err_nx   = 1'b1;
        end
      end
      S_FILL: begin
        if (step_q != 4'd8 && bus.led == fill_pat(step_q + 4'd1)) begin
          step_nx = step_q + 4'd1;
        end else if (bus.led == 8'h00) begin
          state_nx = S_IDLE;
          step_nx  = 4'd0;
          done_nx  = (step_q == 4'd8);
          abort_nx = (step_q != 4'd8);
        end else begin
          state_nx = S_ERR;
          step_nx  = 4'd0;
          err_nx   = 1'b1;
        end
      end
      S_DOT: begin
        if (step_q != 4'd8 && bus.led == dot_pat(step_q + 4'd1)) begin
          step_nx = step_q + 4'd1;
        end else if (bus.led == 8'h00) begin
          state_nx = S_IDLE;
          step_nx  = 4'd0;
          done_nx  = (step_q == 4'd8);
          abort_nx = (step_q != 4'd8);
        end else begin
          state_nx = S_ERR;
          step_nx  = 4'd0;
          err_nx   = 1'b1;
        end
      end
      S_ERR: begin
        step_nx = 4'd0;
        if (bus.led == 8'h00) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        step_nx  = 4'd0;
      end
    endcase
  end

  // Map the upcoming state to the reported mode; ERR reports as idle.
  always_comb begin
    mode_nx = 2'd0;
    case (state_nx)
      S_START: mode_nx = 2'd1;
      S_FILL:  mode_nx = 2'd2;
      S_DOT:   mode_nx = 2'd3;
      default: mode_nx = 2'd0;
    endcase
  end

  // Register state and every output; reset clears all and overrides any transition.
  always_ff @(posedge ck) begin
    if (!rs) begin
      state    <= S_IDLE;
      step_q   <= 4'd0;
      mode_q   <= 2'd0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
      in_err_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state    <= state_nx;
      step_q   <= step_nx;
      mode_q   <= mode_nx;
      done_q   <= done_nx;
      abort_q  <= abort_nx;
      err_q    <= err_nx;
      in_err_q <= (state_nx == S_ERR);
      if (err_nx && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  assign bus.mode    = mode_q;
  assign bus.step    = step_q;
  assign bus.done    = done_q;
  assign bus.abort   = abort_q;
  assign bus.err     = err_q;
  assign bus.in_err  = in_err_q;
  assign bus.err_cnt = cnt_q;

endmodule
